// File: rtl/score_display_pkg.sv
// Shared types and glyph data for the HUD score renderer.
// Segment masks are packed {a,b,c,d,e,f,g}; bit 6 is segment a.
package score_pkg;

  localparam int GLYPH_W = 4;
  localparam int GLYPH_H = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [6:0] SEG_MASK [10] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
    7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
  };

  // Non-decimal nibbles render blank.
  function automatic logic [6:0] seg_mask(input logic [3:0] digit);
    logic [6:0] mask;
    mask = 7'h00;
    if (digit <= 4'd9) mask = SEG_MASK[digit];
    return mask;
  endfunction

endpackage

// File: rtl/score_display_digit_glyph.sv
// Combinational 4x7 seven-segment cell lookup for one digit.
// Coordinates outside the glyph box are masked by the caller.
module digit_glyph
  import score_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic [1:0] i_lx,
  input  logic [2:0] i_ly,
  output logic       o_pixel
);

  logic [6:0] w_mask;
  logic       w_left;
  logic       w_right;
  logic       w_upper;
  logic       w_lower;

  always_comb begin
    w_mask  = seg_mask(i_digit);
    w_left  = (i_lx == 2'd0);
    w_right = (i_lx == 2'd3);
    w_upper = (i_ly <= 3'd3);
    w_lower = (i_ly >= 3'd3);
    o_pixel = (w_mask[6] & (i_ly == 3'd0))
            | (w_mask[5] & w_right & w_upper)
            | (w_mask[4] & w_right & w_lower)
            | (w_mask[3] & (i_ly == 3'd6))
            | (w_mask[2] & w_left & w_lower)
            | (w_mask[1] & w_left & w_upper)
            | (w_mask[0] & (i_ly == 3'd3));
  end

endmodule

// File: rtl/score_display.sv
// BCD score keeper with session high score, record blink and a registered
// 1-bit HUD pixel covering both numbers.
//
// state | meaning
// IDLE  | after reset, no game yet; score frozen at 0
// RUN   | game in progress; increments accepted
// OVER  | game ended; high score latched on entry
module score_display
  import score_pkg::*;
#(
  parameter int CONV         = 0,
  parameter int NUM_DIGITS   = 5,
  parameter int SCORE_X      = 28,
  parameter int HI_X         = 2,
  parameter int Y_POS        = 1,
  parameter int DIGIT_PITCH  = 5,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9-CONV:0]         i_hpos,
  input  logic [9-CONV:0]         i_vpos,
  input  logic                    i_frame_tick,
  input  logic                    i_game_start,
  input  logic                    i_game_over,
  input  logic                    i_score_inc,
  output logic [4*NUM_DIGITS-1:0] o_score_bcd,
  output logic [4*NUM_DIGITS-1:0] o_hi_bcd,
  output logic                    o_new_high,
  output logic                    o_score_color
);

  localparam int PW = 10 - CONV;
  localparam int SW = 4 * NUM_DIGITS;
  localparam int BW = ($clog2(BLINK_FRAMES + 1) > 4) ? $clog2(BLINK_FRAMES + 1) : 4;

  state_t          r_state;
  state_t          w_state_next;
  logic [SW-1:0]   r_score;
  logic [SW-1:0]   r_hi;
  logic [SW-1:0]   w_score_inc;
  logic [BW-1:0]   r_blink;
  logic            r_new_high;
  logic            r_color;
  logic            w_to_over;
  logic            w_record;
  logic            w_count;
  logic            w_sat;
  logic            w_carry;
  logic            w_hi_vis;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_game_start) w_state_next = RUN;
      RUN:     if (!i_game_start && i_game_over) w_state_next = OVER;
      OVER:    if (i_game_start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_to_over = (r_state == RUN) && i_game_over && !i_game_start;
  assign w_count   = (r_state == RUN) && i_score_inc && !i_game_start && !i_game_over;
  // Packed BCD orders the same as the decimal value, so a plain compare works.
  assign w_record  = (r_score > r_hi);

  always_comb begin
    w_score_inc = r_score;
    w_sat       = 1'b1;
    w_carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_sat = w_sat & (r_score[4*i +: 4] == 4'd9);
      if (w_carry) begin
        if (r_score[4*i +: 4] == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;
        end else begin
          w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_score    <= '0;
      r_hi       <= '0;
      r_new_high <= 1'b0;
      r_blink    <= '0;
    end else begin
      if (i_game_start) begin
        r_score    <= '0;
        r_new_high <= 1'b0;
      end else if (w_to_over) begin
        r_new_high <= w_record;
        if (w_record) r_hi <= r_score;
      end else if (w_count && !w_sat) begin
        r_score <= w_score_inc;
      end

      if (w_to_over && w_record) r_blink <= BW'(BLINK_FRAMES);
      else if (i_frame_tick && (r_blink != '0)) r_blink <= r_blink - BW'(1);
    end
  end

  assign w_hi_vis = !((r_blink != '0) && r_blink[3]);

  logic [NUM_DIGITS-1:0] w_score_lz;
  logic [NUM_DIGITS-1:0] w_hi_lz;
  logic                  w_zrun_s;
  logic                  w_zrun_h;

  // Index k counts from the most-significant digit; the LS digit always shows.
  always_comb begin
    w_score_lz = '0;
    w_hi_lz    = '0;
    w_zrun_s   = 1'b1;
    w_zrun_h   = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_zrun_s      = w_zrun_s & (r_score[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      w_zrun_h      = w_zrun_h & (r_hi[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      w_score_lz[k] = w_zrun_s;
      w_hi_lz[k]    = w_zrun_h;
    end
    w_score_lz[NUM_DIGITS-1] = 1'b0;
    w_hi_lz[NUM_DIGITS-1]    = 1'b0;
  end

  logic [PW-1:0]         w_dy;
  logic                  w_row_in;
  logic [NUM_DIGITS-1:0] w_score_px;
  logic [NUM_DIGITS-1:0] w_hi_px;

  assign w_dy     = i_vpos - PW'(Y_POS);
  assign w_row_in = (w_dy < PW'(GLYPH_H));

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int            NIB = NUM_DIGITS - 1 - k;
    localparam logic [PW-1:0] SX  = PW'(SCORE_X + k * DIGIT_PITCH);
    localparam logic [PW-1:0] HX  = PW'(HI_X + k * DIGIT_PITCH);

    logic [PW-1:0] w_sdx;
    logic [PW-1:0] w_hdx;
    logic          w_sgl;
    logic          w_hgl;

    assign w_sdx = i_hpos - SX;
    assign w_hdx = i_hpos - HX;

    digit_glyph u_score_glyph (
      .i_digit (r_score[4*NIB +: 4]),
      .i_lx    (w_sdx[1:0]),
      .i_ly    (w_dy[2:0]),
      .o_pixel (w_sgl)
    );

    digit_glyph u_hi_glyph (
      .i_digit (r_hi[4*NIB +: 4]),
      .i_lx    (w_hdx[1:0]),
      .i_ly    (w_dy[2:0]),
      .o_pixel (w_hgl)
    );

    assign w_score_px[k] = w_sgl & w_row_in & (w_sdx < PW'(GLYPH_W)) & !w_score_lz[k];
    assign w_hi_px[k]    = w_hgl & w_row_in & (w_hdx < PW'(GLYPH_W)) & !w_hi_lz[k] & w_hi_vis;
  end

  always_ff @(posedge clk) begin
    if (rst) r_color <= 1'b0;
    else     r_color <= (|w_score_px) | (|w_hi_px);
  end

  assign o_score_bcd   = r_score;
  assign o_hi_bcd      = r_hi;
  assign o_new_high    = r_new_high;
  assign o_score_color = r_color;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: default build, a 2-digit build and a CONV=1 build
// driven with the same scan so their pixels can be compared to one model.
module tb_score_display;

  localparam int N       = 5;
  localparam int SCORE_X = 28;
  localparam int HI_X    = 2;
  localparam int Y_POS   = 1;
  localparam int PITCH   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hpos, vpos, hfull, vfull;
  logic [8:0]  hpos3, vpos3;
  logic        tick, start, over, inc;
  logic        start2, over2, inc2;
  logic [19:0] score0, hi0, score3, hi3;
  logic [7:0]  score2, hi2;
  logic        nh0, col0, nh2, col2, nh3, col3;

  int n_checks = 0;
  int n_errors = 0;
  int bc = 0;
  logic exp_q[$];
  int   xq[$];

  always #5 clk = ~clk;

  score_display u_dut (
    .clk(clk), .rst(rst), .i_hpos(hpos), .i_vpos(vpos), .i_frame_tick(tick),
    .i_game_start(start), .i_game_over(over), .i_score_inc(inc),
    .o_score_bcd(score0), .o_hi_bcd(hi0), .o_new_high(nh0), .o_score_color(col0)
  );

  score_display #(.NUM_DIGITS(2)) u_dut_nd2 (
    .clk(clk), .rst(rst), .i_hpos(hpos), .i_vpos(vpos), .i_frame_tick(tick),
    .i_game_start(start2), .i_game_over(over2), .i_score_inc(inc2),
    .o_score_bcd(score2), .o_hi_bcd(hi2), .o_new_high(nh2), .o_score_color(col2)
  );

  score_display #(.CONV(1)) u_dut_conv1 (
    .clk(clk), .rst(rst), .i_hpos(hpos3), .i_vpos(vpos3), .i_frame_tick(tick),
    .i_game_start(start), .i_game_over(over), .i_score_inc(inc),
    .o_score_bcd(score3), .o_hi_bcd(hi3), .o_new_high(nh3), .o_score_color(col3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit seg_on(input int d, input int lx, input int ly);
    string segs;
    bit    on;
    on = 1'b0;
    case (d)
      0: segs = "abcdef";
      1: segs = "bc";
      2: segs = "abdeg";
      3: segs = "abcdg";
      4: segs = "bcfg";
      5: segs = "acdfg";
      6: segs = "acdefg";
      7: segs = "abc";
      8: segs = "abcdefg";
      9: segs = "abcdfg";
      default: segs = "";
    endcase
    for (int i = 0; i < segs.len(); i++) begin
      case (segs[i])
        "a": on |= (ly == 0);
        "b": on |= (lx == 3 && ly <= 3);
        "c": on |= (lx == 3 && ly >= 3);
        "d": on |= (ly == 6);
        "e": on |= (lx == 0 && ly >= 3);
        "f": on |= (lx == 0 && ly <= 3);
        "g": on |= (ly == 3);
        default: ;
      endcase
    end
    return on;
  endfunction

  function automatic bit model_px(input int x, input int y, input logic [31:0] sc,
                                  input logic [31:0] hi, input bit hv);
    bit          px, zrun, blank;
    int          org, d, dx, dy;
    logic [31:0] val;
    px = 1'b0;
    dy = y - Y_POS;
    for (int num = 0; num < 2; num++) begin
      org  = (num == 0) ? SCORE_X : HI_X;
      val  = (num == 0) ? sc : hi;
      zrun = 1'b1;
      for (int k = 0; k < N; k++) begin
        d     = int'((val >> (4 * (N - 1 - k))) & 32'hF);
        zrun  = zrun && (d == 0);
        blank = zrun && (k != N - 1);
        dx    = x - (org + k * PITCH);
        if (!blank && dx >= 0 && dx < 4 && dy >= 0 && dy < 7 && (num == 0 || hv))
          px |= seg_on(d, dx, dy);
      end
    end
    return px;
  endfunction

  function automatic bit hi_visible(input int cnt);
    return !(cnt != 0 && (cnt & 8) != 0);
  endfunction

  task automatic pop_check(inout int lit);
    logic e;
    int   x;
    e = exp_q.pop_front();
    x = xq.pop_front();
    check_val("px", 32'(col0), 32'(e));
    check_val("px_conv1", 32'(col3), 32'(e));
    if (col0 && x >= SCORE_X) lit++;
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1,
                      input logic [31:0] sc, input logic [31:0] hi, input bit hv,
                      output int lit);
    lit = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        step();
        if (exp_q.size() > 0) pop_check(lit);
        hpos  = 10'(x);
        vpos  = 10'(y);
        hfull = 10'(2 * x);
        vfull = 10'(2 * y);
        hpos3 = hfull[9:1];
        vpos3 = vfull[9:1];
        exp_q.push_back(model_px(x, y, sc, hi, hv));
        xq.push_back(x);
      end
    end
    step();
    while (exp_q.size() > 0) pop_check(lit);
    hpos = '0; vpos = '0; hpos3 = '0; vpos3 = '0;
  endtask

  task automatic pulse_start();  start = 1'b1; step(); start = 1'b0; endtask
  task automatic pulse_over();   over  = 1'b1; step(); over  = 1'b0; endtask
  task automatic pulse_tick();   tick  = 1'b1; step(); tick  = 1'b0; endtask
  task automatic inc_n(input int n);  inc  = 1'b1; repeat (n) step(); inc  = 1'b0; endtask
  task automatic inc2_n(input int n); inc2 = 1'b1; repeat (n) step(); inc2 = 1'b0; endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    bc = 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit;
    rst = 1'b1;
    hpos = '0; vpos = '0; hpos3 = '0; vpos3 = '0; hfull = '0; vfull = '0;
    tick = 1'b0; start = 1'b0; over = 1'b0; inc = 1'b0;
    start2 = 1'b0; over2 = 1'b0; inc2 = 1'b0;
    step(); step();
    check_val("rst_score", 32'(score0), 0);
    check_val("rst_hi", 32'(hi0), 0);
    check_val("rst_nh", 32'(nh0), 0);
    check_val("rst_color", 32'(col0), 0);
    rst = 1'b0;

    // over and inc while IDLE are ignored
    pulse_over();
    check_val("idle_over_hi", 32'(hi0), 0);
    check_val("idle_over_nh", 32'(nh0), 0);
    inc_n(5);
    check_val("idle_no_inc", 32'(score0), 0);

    // reset mid-game
    pulse_start();
    inc_n(123);
    check_val("score_123", 32'(score0), to_bcd(123));
    hpos = 10'd48; vpos = 10'd1; step();
    check_val("pre_rst_px", 32'(col0), 32'(model_px(48, 1, to_bcd(123), 0, 1'b1)));
    rst = 1'b1; step();
    check_val("rst_mid_color", 32'(col0), 0);
    check_val("rst_mid_score", 32'(score0), 0);
    check_val("rst_mid_hi", 32'(hi0), 0);
    step(); rst = 1'b0; hpos = '0; vpos = '0;
    inc_n(3);
    check_val("post_rst_idle", 32'(score0), 0);

    // decimal carry
    pulse_start();
    inc_n(999);
    check_val("score_999", 32'(score0), to_bcd(999));
    inc_n(1);
    check_val("carry_1000", 32'(score0), to_bcd(1000));
    check_val("conv1_score", 32'(score3), to_bcd(1000));
    do_reset();

    // two-digit saturation and priorities
    start2 = 1'b1; step(); start2 = 1'b0;
    inc2_n(99);
    check_val("nd2_99", 32'(score2), 32'h99);
    inc2_n(3);
    check_val("nd2_sat", 32'(score2), 32'h99);
    start2 = 1'b1; inc2 = 1'b1; step(); start2 = 1'b0; inc2 = 1'b0;
    check_val("nd2_start_inc", 32'(score2), 0);
    inc2_n(5);
    start2 = 1'b1; over2 = 1'b1; step(); start2 = 1'b0; over2 = 1'b0;
    check_val("nd2_start_over", 32'(score2), 0);
    inc2_n(1);
    check_val("nd2_still_run", 32'(score2), 32'h01);
    over2 = 1'b1; step(); over2 = 1'b0;
    check_val("nd2_hi", 32'(hi2), 32'h01);
    check_val("nd2_nh", 32'(nh2), 1);
    check_val("nd2_px_off", 32'(col2), 0);

    // high score, equal score, blink
    pulse_start();
    inc_n(42);
    pulse_over();
    check_val("hi_42", 32'(hi0), to_bcd(42));
    check_val("nh_set", 32'(nh0), 1);
    check_val("conv1_hi", 32'(hi3), to_bcd(42));
    bc = 64;
    pulse_start();
    check_val("nh_clr_start", 32'(nh0), 0);
    check_val("score_clr", 32'(score0), 0);
    inc_n(42);
    pulse_over();
    check_val("hi_equal", 32'(hi0), to_bcd(42));
    check_val("nh_equal", 32'(nh0), 0);
    check_val("conv1_nh", 32'(nh3), 0);
    for (int t = 0; t < 68; t++) begin
      scan(17, 26, 1, 7, to_bcd(42), to_bcd(42), hi_visible(bc), lit);
      pulse_tick();
      if (bc > 0) bc--;
    end

    // full render of score 7
    do_reset();
    pulse_start();
    inc_n(7);
    scan(0, 55, 0, 8, to_bcd(7), 0, hi_visible(bc), lit);
    check_val("lit7", 32'(lit), 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
